// File: rtl/alu_const_select_decode.sv
// Registered decode of the 5-bit ALU constant-select code into an 18-bit one-hot mux select,
// with a 2-entry skid buffer on a valid/ready handshake and illegal-code error tracking.
module alu_const_select_decode #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [17:0]      out_sel,
   output logic             out_illegal,
   input  logic             err_clr,
   output logic             err_sticky,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [17:0]      w_sel;
   logic             w_illegal;
   logic             w_accept;
   logic             w_drain;

   logic             r_main_valid;
   logic [17:0]      r_main_sel;
   logic             r_main_ill;
   logic             r_skid_valid;
   logic [17:0]      r_skid_sel;
   logic             r_skid_ill;
   logic             r_err_sticky;
   logic [CNT_W-1:0] r_err_count;

   always_comb begin
      w_sel     = '0;
      w_illegal = 1'b0;
      case (in_code)
         5'h00:   w_sel = 18'h00000;
         5'h01:   w_sel = 18'h00001;
         5'h02:   w_sel = 18'h00002;
         5'h03:   w_sel = 18'h00004;
         5'h04:   w_sel = 18'h00008;
         5'h05:   w_sel = 18'h00010;
         5'h06:   w_sel = 18'h00020;
         5'h07:   w_sel = 18'h00040;
         5'h08:   w_sel = 18'h00080;
         5'h09:   w_sel = 18'h00100;
         5'h0A:   w_sel = 18'h00200;
         5'h0B:   w_sel = 18'h00400;
         5'h0C:   w_sel = 18'h00800;
         5'h0D:   w_sel = 18'h01000;
         5'h0E:   w_sel = 18'h02000;
         5'h0F:   w_sel = 18'h04000;
         5'h10:   w_sel = 18'h08000;
         5'h11:   w_sel = 18'h10000;
         5'h12:   w_sel = 18'h20000;
         default: w_illegal = 1'b1;
      endcase
   end

   // Skid is only ever filled behind a full main, so !skid_valid alone gates acceptance.
   assign in_ready = ~r_skid_valid;
   assign w_accept = in_valid & ~r_skid_valid;
   assign w_drain  = r_main_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_main_sel   <= '0;
         r_main_ill   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_sel   <= '0;
         r_skid_ill   <= 1'b0;
      end else if (w_drain && r_skid_valid) begin
         r_main_sel   <= r_skid_sel;
         r_main_ill   <= r_skid_ill;
         r_skid_valid <= 1'b0;
         r_skid_sel   <= '0;
         r_skid_ill   <= 1'b0;
      end else if (w_accept && (!r_main_valid || w_drain)) begin
         r_main_valid <= 1'b1;
         r_main_sel   <= w_sel;
         r_main_ill   <= w_illegal;
      end else if (w_accept) begin
         r_skid_valid <= 1'b1;
         r_skid_sel   <= w_sel;
         r_skid_ill   <= w_illegal;
      end else if (w_drain) begin
         // Clearing sel keeps the mux select all-zero whenever out_valid is low.
         r_main_valid <= 1'b0;
         r_main_sel   <= '0;
         r_main_ill   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
      end else if (w_accept && w_illegal) begin
         r_err_sticky <= 1'b1;
         if (err_clr) begin
            r_err_count <= CNT_W'(1);
         end else if (r_err_count != CntMax) begin
            r_err_count <= r_err_count + CNT_W'(1);
         end
      end else if (err_clr) begin
         r_err_sticky <= 1'b0;
         r_err_count  <= '0;
      end
   end

   assign out_valid   = r_main_valid;
   assign out_sel     = r_main_sel;
   assign out_illegal = r_main_ill;
   assign err_sticky  = r_err_sticky;
   assign err_count   = r_err_count;

endmodule

// File: tb/tb_alu_const_select_decode.sv
// Directed and randomized self-checking bench for alu_const_select_decode.
module tb_alu_const_select_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_code;
   logic        out_valid;
   logic        out_ready;
   logic [17:0] out_sel;
   logic        out_illegal;
   logic        err_clr;
   logic        err_sticky;
   logic [3:0]  err_count;

   int n_total = 0;
   int n_bad   = 0;

   alu_const_select_decode #(.CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_code     (in_code),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sel     (out_sel),
      .out_illegal (out_illegal),
      .err_clr     (err_clr),
      .err_sticky  (err_sticky),
      .err_count   (err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected {illegal, sel} for a code.
   function automatic logic [18:0] model_dec(input logic [4:0] c);
      if (c == 5'd0) return 19'd0;
      if (c <= 5'd18) return {1'b0, 18'(1) << (c - 5'd1)};
      return {1'b1, 18'd0};
   endfunction

   logic [18:0] q[$];
   int          m_cnt;
   bit          m_sticky;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; err_clr = 1'b0;
      step(); step();
      rst = 1'b0;
      check("rst_valid", 32'(out_valid), 0);
      check("rst_sel", 32'(out_sel), 0);
      check("rst_ill", 32'(out_illegal), 0);
      check("rst_ready", 32'(in_ready), 1);
      check("rst_sticky", 32'(err_sticky), 0);
      check("rst_count", 32'(err_count), 0);

      // Sweep legal codes back-to-back.
      out_ready = 1'b1;
      for (int c = 0; c <= 18; c++) begin
         in_valid = 1'b1; in_code = 5'(c);
         step();
         check("sweep_valid", 32'(out_valid), 1);
         check("sweep_sel", 32'(out_sel), (c == 0) ? 0 : (32'd1 << (c - 1)));
         check("sweep_ill", 32'(out_illegal), 0);
         check("sweep_ready", 32'(in_ready), 1);
      end
      in_valid = 1'b0;
      step();
      check("sweep_empty_valid", 32'(out_valid), 0);
      check("sweep_empty_sel", 32'(out_sel), 0);

      // Backpressure.
      out_ready = 1'b0;
      in_valid = 1'b1; in_code = 5'h04;
      step();
      check("bp_sel0", 32'(out_sel), 32'h00008);
      check("bp_ready0", 32'(in_ready), 1);
      in_code = 5'h0C;
      step();
      check("bp_ready1", 32'(in_ready), 0);
      check("bp_sel1", 32'(out_sel), 32'h00008);
      in_code = 5'h11;
      step();
      check("bp_hold_ready", 32'(in_ready), 0);
      check("bp_hold_sel", 32'(out_sel), 32'h00008);
      out_ready = 1'b1;
      step();
      check("bp_out_b11", 32'(out_sel), 32'h00800);
      check("bp_ready_back", 32'(in_ready), 1);
      step();
      check("bp_out_b16", 32'(out_sel), 32'h10000);
      in_valid = 1'b0;
      step();
      check("bp_drained", 32'(out_valid), 0);
      check("bp_drained_sel", 32'(out_sel), 0);

      // Illegal codes.
      in_valid = 1'b1; in_code = 5'h13;
      step();
      check("ill13_valid", 32'(out_valid), 1);
      check("ill13_ill", 32'(out_illegal), 1);
      check("ill13_sel", 32'(out_sel), 0);
      in_code = 5'h1F;
      step();
      check("ill1f_ill", 32'(out_illegal), 1);
      check("ill1f_sel", 32'(out_sel), 0);
      in_code = 5'h05;
      step();
      check("ill_then_b4", 32'(out_sel), 32'h00010);
      check("ill_then_ill", 32'(out_illegal), 0);
      check("ill_sticky", 32'(err_sticky), 1);
      check("ill_count", 32'(err_count), 2);

      // Saturation and clear.
      for (int i = 0; i < 20; i++) begin
         in_code = 5'(19 + (i % 13));
         step();
      end
      check("sat_count", 32'(err_count), 15);
      in_valid = 1'b0; err_clr = 1'b1;
      step();
      check("clr_count", 32'(err_count), 0);
      check("clr_sticky", 32'(err_sticky), 0);
      in_valid = 1'b1; in_code = 5'h15;
      step();
      check("clr_ill_count", 32'(err_count), 1);
      check("clr_ill_sticky", 32'(err_sticky), 1);
      err_clr = 1'b0; in_valid = 1'b0;
      step();

      // Reset with both entries full.
      out_ready = 1'b0;
      in_valid = 1'b1; in_code = 5'h01;
      step();
      in_code = 5'h02;
      step();
      check("full_ready", 32'(in_ready), 0);
      rst = 1'b1; in_code = 5'h13; err_clr = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0; err_clr = 1'b0;
      check("mrst_valid", 32'(out_valid), 0);
      check("mrst_sel", 32'(out_sel), 0);
      check("mrst_ready", 32'(in_ready), 1);
      check("mrst_count", 32'(err_count), 0);
      check("mrst_sticky", 32'(err_sticky), 0);
      out_ready = 1'b1;
      step(); step();
      check("mrst_no_stale", 32'(out_valid), 0);

      // Random traffic against a queue model.
      q.delete();
      m_cnt = 0; m_sticky = 0;
      for (int i = 0; i < 10000; i++) begin
         bit acc, drn;
         logic [18:0] d;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_code   = 5'($urandom_range(0, 31));
         out_ready = ($urandom_range(0, 2) != 0);
         err_clr   = ($urandom_range(0, 15) == 0);
         acc = in_valid && (q.size() < 2);
         drn = (q.size() > 0) && out_ready && !(q.size() == 2 && 0);
         d = model_dec(in_code);
         step();
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(d);
         if (acc && d[18]) begin
            m_sticky = 1;
            m_cnt = err_clr ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
         end else if (err_clr) begin
            m_sticky = 0; m_cnt = 0;
         end
         check("rnd_valid", 32'(out_valid), 32'(q.size() > 0));
         check("rnd_sel", 32'(out_sel), (q.size() > 0) ? 32'(q[0][17:0]) : 0);
         check("rnd_ill", 32'(out_illegal), (q.size() > 0) ? 32'(q[0][18]) : 0);
         check("rnd_ready", 32'(in_ready), 32'(q.size() < 2));
         check("rnd_onehot", 32'($countones(out_sel) <= 1), 1);
         check("rnd_zero_idle", 32'(out_valid || (out_sel == 18'd0)), 1);
         check("rnd_count", 32'(err_count), 32'(m_cnt));
         check("rnd_sticky", 32'(err_sticky), 32'(m_sticky));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
